// File: rtl/fetch_frontend.sv
// Instruction-fetch front end with IF/ID register: single-outstanding imem port,
// one-entry hold buffer for decode stalls and a DRAIN state that squashes stale responses.
module fetch_frontend #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallf,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        pcSrce,
  input  logic [31:0] pcTargete,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pcf,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcplus4d,
  output logic        validd,
  output logic        dbg_state
);

  // Handshake: a request transfers on a rising edge where imem_req_valid and
  // imem_req_ready are both high; a response is a single-cycle imem_rsp_valid strobe.
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state;
  logic        outst;
  logic [31:0] pend_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        accept;
  logic        rsp_run;
  logic        src_valid;
  logic [31:0] src_instr;
  logic [31:0] src_pc;

  always_comb begin
    imem_req_valid = !rst && (state == RUN) && !pcSrce && !stallf && !stalld &&
                     !buf_valid && (!outst || imem_rsp_valid);
    accept    = imem_req_valid && imem_req_ready;
    rsp_run   = imem_rsp_valid && (state == RUN);
    // Anything fetched on the old path is dropped in the cycle a redirect is taken.
    src_valid = !pcSrce && (buf_valid || rsp_run);
    src_instr = buf_valid ? buf_instr : imem_rsp_data;
    src_pc    = buf_valid ? buf_pc : pend_pc;
  end

  assign imem_addr = pcf;
  assign dbg_state = (state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pcf       <= RESET_PC;
      outst     <= 1'b0;
      pend_pc   <= 32'd0;
      buf_valid <= 1'b0;
      buf_instr <= 32'd0;
      buf_pc    <= 32'd0;
      validd    <= 1'b0;
      instrd    <= NOP;
      pcd       <= 32'd0;
      pcplus4d  <= 32'd0;
    end else begin
      if (pcSrce) begin
        pcf <= pcTargete;
      end else if (accept) begin
        pcf <= pcf + 32'd4;
      end

      if (accept) begin
        pend_pc <= pcf;
        outst   <= 1'b1;
      end else if (imem_rsp_valid) begin
        outst <= 1'b0;
      end

      case (state)
        RUN:     if (pcSrce && outst && !imem_rsp_valid) state <= DRAIN;
        DRAIN:   if (imem_rsp_valid) state <= RUN;
        default: state <= RUN;
      endcase

      if (pcSrce) begin
        buf_valid <= 1'b0;
      end else if (!flushd) begin
        if (stalld) begin
          if (rsp_run && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_instr <= imem_rsp_data;
            buf_pc    <= pend_pc;
          end
        end else if (buf_valid) begin
          buf_valid <= 1'b0;
        end
      end

      if (flushd) begin
        validd   <= 1'b0;
        instrd   <= NOP;
        pcd      <= 32'd0;
        pcplus4d <= 32'd0;
      end else if (!stalld) begin
        if (src_valid) begin
          validd   <= 1'b1;
          instrd   <= src_instr;
          pcd      <= src_pc;
          pcplus4d <= src_pc + 32'd4;
        end else begin
          validd   <= 1'b0;
          instrd   <= NOP;
          pcd      <= 32'd0;
          pcplus4d <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_frontend.sv
// Bench for fetch_frontend: in-order variable-latency memory model, program-order
// expectation queue consumed by a decode-stage monitor, directed and random phases.
module tb_fetch_frontend;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stallf = 1'b0, stalld = 1'b0, flushd = 1'b0, pcSrce = 1'b0;
  logic [31:0] pcTargete = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic [31:0] pcf, instrd, pcd, pcplus4d;
  logic        validd, dbg_state;

  fetch_frontend #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stallf(stallf), .stalld(stalld), .flushd(flushd),
    .pcSrce(pcSrce), .pcTargete(pcTargete),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pcf(pcf), .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d),
    .validd(validd), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_decoded = 0;

  // Program-order expectation: the PCs decode must present, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] mon_exp;

  // Memory model state
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  bit          last_accept = 1'b0;

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_tail = start;
    top_up();
  endfunction

  // Memory: in-order, latency lat_min..lat_max edges after acceptance.
  task automatic mem_drive();
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom();
      imem_req_ready = 1'($urandom_range(0, 1));
    end else begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq_addr.pop_front() + 32'h100;
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
      end
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    if (rst) check32("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
    if (!rst && prev_wait && !pcSrce && !stallf && !stalld) begin
      check32("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      check32("req_hold_addr", imem_addr, prev_addr);
    end
    last_accept = !rst && imem_req_valid && imem_req_ready;
    if (last_accept) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end
    prev_wait = !rst && imem_req_valid && !imem_req_ready;
    prev_addr = imem_addr;
    cyc++;
  endtask

  // Driver: called at a negedge; applies inputs for the next edge and returns at the next negedge.
  task automatic step(input bit sf, input bit sd, input bit redir, input logic [31:0] tgt);
    stallf    = sf;
    stalld    = sd;
    pcSrce    = redir;
    flushd    = redir;
    pcTargete = redir ? tgt : $urandom();
    if (rst) restart_stream(RESET_PC);
    else if (redir) restart_stream(tgt);
    top_up();
    mem_drive();
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check32("rst_pcf", pcf, RESET_PC);
    check32("rst_validd", {31'd0, validd}, 32'd0);
    check32("rst_instrd", instrd, NOP);
    check32("rst_pcd", pcd, 32'd0);
    check32("rst_pcplus4d", pcplus4d, 32'd0);
    check32("rst_state", {31'd0, dbg_state}, 32'd0);
  endtask

  // Monitor: every new decode instruction must be the next one in program order.
  always @(posedge clk) begin
    #1;
    if (validd && !stalld) begin
      n_decoded++;
      if (exp_q.size() == 0) begin
        check32("decode_unexpected", pcd, 32'hxxxx_xxxx);
      end else begin
        mon_exp = exp_q.pop_front();
        check32("decode_pc", pcd, mon_exp);
        check32("decode_instr", instrd, mon_exp + 32'h100);
        check32("decode_pcplus4", pcplus4d, mon_exp + 32'd4);
      end
    end
  end

  int stall_left = 0;
  int stall_mode = 0;
  bit found;
  logic [31:0] tgt;

  initial begin
    restart_stream(RESET_PC);
    @(negedge clk);

    // Reset with junk responses on the bus
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 32'd0);
    check_reset_vals();

    // Streaming: 1-cycle memory, always ready
    rst = 1'b0;
    lat_min = 1; lat_max = 1; ready_pct = 100;
    for (int i = 0; i < 16; i++) begin
      check32("stream_addr", imem_addr, 32'(4 * i));
      check32("stream_validd", {31'd0, validd}, (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) check32("stream_pcd", pcd, 32'(4 * (i - 2)));
      step(0, 0, 0, 32'd0);
    end

    // Decode stall while the 0x3C response is in flight
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'd0);
      check32("stall_pcf", pcf, 32'h40);
      check32("stall_pcd", pcd, 32'h38);
    end
    step(0, 0, 0, 32'd0);
    check32("release_pcd", pcd, 32'h3C);
    check32("release_validd", {31'd0, validd}, 32'd1);
    check32("release_pcf", pcf, 32'h40);
    step(0, 0, 0, 32'd0);
    check32("resume_pcf", pcf, 32'h44);

    // Redirect while a slow request is outstanding
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 32'd0);
      found = last_accept;
    end
    check32("drain_setup", {31'd0, found}, 32'd1);
    step(0, 0, 1, 32'h300);
    check32("drain_entered", {31'd0, dbg_state}, 32'd1);
    check32("drain_pcf", pcf, 32'h300);
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    check32("drain_exit", {31'd0, dbg_state}, 32'd0);
    repeat (15) step(0, 0, 0, 32'd0);

    // Wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    step(0, 0, 1, 32'hFFFF_FFFC);
    check32("wrap_pcf", pcf, 32'hFFFF_FFFC);
    repeat (10) step(0, 0, 0, 32'd0);

    // Random phases
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin lat_min = 1; lat_max = 1; ready_pct = 100; end
        1: begin lat_min = 1; lat_max = 3; ready_pct = 70; end
        2: begin lat_min = 2; lat_max = 5; ready_pct = 50; end
        default: begin lat_min = 1; lat_max = 4; ready_pct = 30; end
      endcase
      for (int i = 0; i < 500; i++) begin
        if (stall_left == 0 && $urandom_range(0, 99) < 12) begin
          stall_left = $urandom_range(1, 4);
          stall_mode = $urandom_range(0, 2);
        end
        case ($urandom_range(0, 2))
          0: tgt = {$urandom() >> 2, 2'b00};
          1: tgt = 32'hFFFF_FFF8;
          default: tgt = 32'h200;
        endcase
        step(stall_left > 0 && stall_mode != 2, stall_left > 0 && stall_mode != 1,
             $urandom_range(0, 99) < 3, tgt);
        if (stall_left > 0) stall_left--;
      end
    end

    // Reset with a request in flight
    lat_min = 4; lat_max = 4; ready_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 32'd0);
      found = last_accept;
    end
    check32("midrst_setup", {31'd0, found}, 32'd1);
    rst = 1'b1;
    repeat (2) step(0, 0, 0, 32'd0);
    check_reset_vals();
    rst = 1'b0;
    lat_min = 1; lat_max = 1;
    check32("midrst_first_addr", imem_addr, RESET_PC);
    repeat (20) step(0, 0, 0, 32'd0);

    check32("progress", {31'd0, n_decoded >= 300}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_frontend.md
# fetch_frontend

Instruction-fetch front end and IF/ID pipeline register that carries out the hazard unit's commands. It consumes `stallf`, `stalld`, `flushd` and `pcSrce`, and drives the PC through a valid/ready instruction-memory port that allows one outstanding request. Fetched instructions go into the decode-stage register. A one-entry hold buffer and a drain state make stalls and redirects safe against variable memory latency.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP`, default 32'h0000_0013: instruction (addi x0,x0,0) placed in decode on flush or bubble.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stallf` input 1: hold the fetch PC and issue no request.
- `stalld` input 1: hold the IF/ID register.
- `flushd` input 1: replace the IF/ID contents with a bubble.
- `pcSrce` input 1: redirect taken in execute.
- `pcTargete` input 32: redirect target.
- `imem_req_valid` output 1: fetch request.
- `imem_req_ready` input 1: memory accepts the request. A request is accepted when `imem_req_valid` and `imem_req_ready` are both high.
- `imem_addr` output 32: request address (equals `pcf`).
- `imem_rsp_valid` input 1: response strobe. Responses arrive in order, at least 1 cycle after acceptance.
- `imem_rsp_data` input 32: instruction word.
- `pcf` output 32: current fetch PC.
- `instrd`, `pcd`, `pcplus4d` output 32 each: decode-stage instruction, its PC, and its PC+4.
- `validd` output 1: decode holds a real instruction.

## Operation

- State:
  - `pcf`.
  - `outst`: 0 or 1, number of outstanding requests.
  - `pend_pc`: address of the outstanding request.
  - Hold buffer: `buf_valid`, `buf_instr`, `buf_pc`.
  - FSM with states RUN and DRAIN.
- Issue condition: `imem_req_valid = state==RUN && !pcSrce && !stallf && !stalld && !buf_valid && (outst==0 || imem_rsp_valid)`.
- On acceptance:
  - `pend_pc <= pcf`, `pcf <= pcf+4` (mod 2^32, wraps from 32'hFFFF_FFFC to 0).
  - `outst` stays 1 if a response also arrives that cycle; otherwise it becomes 1.
- A response with no acceptance in the same cycle sets `outst <= 0`.
- Instruction source for decode, in priority order: `buf_valid` (buffer contents), else `imem_rsp_valid` in RUN (`imem_rsp_data`, `pend_pc`).
- IF/ID update, in priority order:
  - `flushd`: `validd<=0`, `instrd<=NOP`, `pcd<=0`, `pcplus4d<=0`.
  - `stalld`: hold all IF/ID fields. A response arriving in RUN with the buffer empty is captured into the buffer.
  - Source available: load it, `validd<=1`, `pcplus4d<=pc+4`. Clear `buf_valid` if the buffer was the source.
  - Otherwise load a bubble, same values as the flush case.
- Redirect (`pcSrce`):
  - `pcf <= pcTargete`, overriding `stallf` and any acceptance.
  - `buf_valid <= 0`.
  - A response arriving in the same cycle is discarded.
  - If `outst==1` and no response arrives this cycle, go to DRAIN.
- DRAIN:
  - No issue.
  - The next response is discarded, `outst<=0`, then return to RUN.
  - A further `pcSrce` while in DRAIN only updates `pcf`.
- `stallf` alone holds `pcf`. An outstanding response still lands in decode or the buffer.

## Timing

- Reset values:
  - `pcf=RESET_PC`, `outst=0`, `buf_valid=0`, state RUN.
  - `imem_req_valid=0` while `rst` is high.
  - `validd=0`, `instrd=NOP`, `pcd=0`, `pcplus4d=0`.
- `rst` mid-operation discards any in-flight request. The memory shares `rst`, and responses seen while `rst` is high are ignored.
- Latency with an always-ready memory and 1-cycle response:
  - Request accepted in cycle n, response in cycle n+1.
  - The instruction is visible on `instrd` in cycle n+2.
  - Throughput is 1 instruction per cycle.
- Redirect asserted in cycle n:
  - First request to the target is issued in cycle n+1 if `outst` is 0 after cycle n.
  - Otherwise it is issued in the cycle after the drained response.
- Release from stall: when `stalld` falls with `buf_valid=1`, the buffer loads into decode on that edge. Issue resumes in the following cycle.

## Test plan

- Reset, then ready=1 with 1-cycle responses returning `addr+0x100`:
  - `imem_addr` sequence is 0, 4, 8, …
  - `instrd` is 0x100 at cycle 2, 0x104 at cycle 3, with `validd` high and `pcplus4d = pcd+4`.
- `stallf`/`stalld` held for 3 cycles while the response for 0x8 is in flight:
  - The 0x8 response is captured in the buffer.
  - `pcf` holds 0xC and decode holds the 0x4 instruction.
  - After release, the 0x8 instruction appears next, then 0xC. No duplicate and no loss.
- `pcSrce`+`flushd` with `pcTargete=0x200` and no outstanding request:
  - `validd=0` and `instrd=NOP` the next cycle.
  - Next `imem_addr` is 0x200.
- Memory with 3-cycle latency, redirect to 0x300 while a request to 0x10 is outstanding:
  - FSM enters DRAIN and the 0x10 response never reaches decode.
  - Next request is 0x300.
- `imem_req_ready` low for 4 cycles:
  - `imem_req_valid` and `imem_addr` stay stable and `pcf` is unchanged.
  - Decode receives bubbles (`validd=0`).
- `pcTargete=0xFFFF_FFFC`:
  - Next request address is 0xFFFF_FFFC, then 0x0.
  - `pcplus4d` for that instruction is 0x0.
- `rst` asserted with a request outstanding:
  - All reset values restored.
  - The first post-reset request is to `RESET_PC`.
